// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and helpers for the program-counter fetch unit.
package pc_fetch_unit_pkg;

    typedef enum logic [1:0] {
        CTRL_TRANS_SEL_NONE   = 2'd0,
        CTRL_TRANS_SEL_JUMP   = 2'd1,
        CTRL_TRANS_SEL_BRANCH = 2'd2
    } ctrl_trans_sel_e;

    typedef enum logic [1:0] {
        PC_STATE_BOOT = 2'd0,
        PC_STATE_RUN  = 2'd1,
        PC_STATE_HALT = 2'd2
    } pc_state_e;

    // A target is misaligned when it is not a multiple of the instruction
    // alignment: 4 bytes without compressed support, 2 bytes with it.
    function automatic logic is_misaligned(input logic [1:0] low_bits, input int ialign);
        if (ialign == 16) begin
            return low_bits[0];
        end
        return (low_bits != 2'b00);
    endfunction

endpackage

// File: rtl/pc_redirect_arb.sv
// Redirect arbiter: picks the highest-priority control transfer, computes its
// target and flags a misaligned non-trap target. Purely combinational.
module pc_redirect_arb
    import pc_fetch_unit_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int IALIGN = 32
) (
    input  logic [1:0]      ctrl_trans_instr_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] offset_i,
    input  logic            branch_tkn_i,
    input  logic [XLEN-1:0] tgt_addr_i,
    input  logic            trap_i,
    input  logic [XLEN-1:0] mtvec_i,
    input  logic            mret_i,
    input  logic [XLEN-1:0] mepc_i,
    output logic            redir_valid_o,
    output logic            redir_trap_o,
    output logic [XLEN-1:0] redir_tgt_o,
    output logic            misalign_o
);

    // Priority: trap > mret > jump > taken branch; anything else is sequential.
    always_comb begin
        redir_valid_o = 1'b0;
        redir_trap_o  = 1'b0;
        redir_tgt_o   = '0;
        if (trap_i) begin
            redir_valid_o = 1'b1;
            redir_trap_o  = 1'b1;
            redir_tgt_o   = mtvec_i;
        end else if (mret_i) begin
            redir_valid_o = 1'b1;
            redir_tgt_o   = mepc_i;
        end else if (ctrl_trans_instr_i == CTRL_TRANS_SEL_JUMP) begin
            redir_valid_o = 1'b1;
            redir_tgt_o   = {tgt_addr_i[XLEN-1:1], 1'b0};
        end else if ((ctrl_trans_instr_i == CTRL_TRANS_SEL_BRANCH) && branch_tkn_i) begin
            redir_valid_o = 1'b1;
            redir_tgt_o   = pc_i + offset_i;
        end
    end

    // The trap vector is trusted and never raises a misalign.
    assign misalign_o = redir_valid_o && !redir_trap_o &&
                        is_misaligned(redir_tgt_o[1:0], IALIGN);

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter with fetch handshake, one-deep pending-redirect buffer,
// misalign halt and trap recovery.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_ADDR = '0,
    parameter int              IALIGN     = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      ctrl_trans_instr_i,
    input  logic [XLEN-1:0] offset_i,
    input  logic            branch_tkn_i,
    input  logic [XLEN-1:0] tgt_addr_i,
    input  logic            c_instr_i,
    input  logic            trap_i,
    input  logic [XLEN-1:0] mtvec_i,
    input  logic            mret_i,
    input  logic [XLEN-1:0] mepc_i,
    input  logic            stall_i,
    input  logic            fetch_ready_i,
    output logic            fetch_valid_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_link_o,
    output logic            misalign_o,
    output logic [XLEN-1:0] misalign_addr_o
);

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            pend_vld_q, pend_vld_d;
    logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;
    logic            misalign_q, misalign_d;
    logic [XLEN-1:0] misalign_addr_q, misalign_addr_d;

    logic            redir_valid;
    logic            redir_trap;
    logic [XLEN-1:0] redir_tgt;
    logic            redir_misalign;
    logic            adv;

    pc_redirect_arb #(
        .XLEN   (XLEN),
        .IALIGN (IALIGN)
    ) u_arb (
        .ctrl_trans_instr_i (ctrl_trans_instr_i),
        .pc_i               (pc_q),
        .offset_i           (offset_i),
        .branch_tkn_i       (branch_tkn_i),
        .tgt_addr_i         (tgt_addr_i),
        .trap_i             (trap_i),
        .mtvec_i            (mtvec_i),
        .mret_i             (mret_i),
        .mepc_i             (mepc_i),
        .redir_valid_o      (redir_valid),
        .redir_trap_o       (redir_trap),
        .redir_tgt_o        (redir_tgt),
        .misalign_o         (redir_misalign)
    );

    assign fetch_valid_o   = (state_q == PC_STATE_RUN);
    assign pc_o            = pc_q;
    assign pc_link_o       = pc_q + ((IALIGN == 16 && c_instr_i) ? XLEN'(2) : XLEN'(4));
    assign misalign_o      = misalign_q;
    assign misalign_addr_o = misalign_addr_q;
    assign adv             = (state_q == PC_STATE_RUN) && fetch_valid_o &&
                             fetch_ready_i && !stall_i;

    // Next-state logic: trap overrides everything outside BOOT; otherwise a
    // redirect either loads on advance or waits in the pending buffer.
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        pend_vld_d      = pend_vld_q;
        pend_tgt_d      = pend_tgt_q;
        misalign_d      = 1'b0;
        misalign_addr_d = misalign_addr_q;
        case (state_q)
            PC_STATE_BOOT: begin
                state_d = PC_STATE_RUN;
            end
            PC_STATE_RUN: begin
                if (redir_trap) begin
                    pc_d       = redir_tgt;
                    pend_vld_d = 1'b0;
                end else if (!pend_vld_q && redir_misalign) begin
                    // Bad target: report it and stop fetching until a trap.
                    misalign_d      = 1'b1;
                    misalign_addr_d = redir_tgt;
                    state_d         = PC_STATE_HALT;
                    pend_vld_d      = 1'b0;
                end else if (adv) begin
                    if (pend_vld_q) begin
                        pc_d = pend_tgt_q;
                    end else if (redir_valid) begin
                        pc_d = redir_tgt;
                    end else begin
                        pc_d = pc_link_o;
                    end
                    pend_vld_d = 1'b0;
                end else if (redir_valid && !pend_vld_q) begin
                    pend_vld_d = 1'b1;
                    pend_tgt_d = redir_tgt;
                end
            end
            PC_STATE_HALT: begin
                if (redir_trap) begin
                    pc_d       = redir_tgt;
                    state_d    = PC_STATE_RUN;
                    pend_vld_d = 1'b0;
                end
            end
            default: begin
                state_d = PC_STATE_BOOT;
            end
        endcase
    end

    // Control and architectural state, with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= PC_STATE_BOOT;
            pc_q            <= RESET_ADDR;
            pend_vld_q      <= 1'b0;
            misalign_q      <= 1'b0;
            misalign_addr_q <= '0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            pend_vld_q      <= pend_vld_d;
            misalign_q      <= misalign_d;
            misalign_addr_q <= misalign_addr_d;
        end
    end

    // Pending target is only meaningful while its valid bit is set.
    always_ff @(posedge clk) begin
        pend_tgt_q <= pend_tgt_d;
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: two instances (IALIGN=32 with RESET_ADDR=0x100,
// IALIGN=16 with RESET_ADDR=0) share stimulus; a reference model predicts each
// cycle's outputs into per-instance queues that a monitor drains.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  ctrl;
    logic [31:0] offset;
    logic        tkn;
    logic [31:0] tgt;
    logic        c_instr;
    logic        trap;
    logic [31:0] mtvec;
    logic        mret;
    logic [31:0] mepc;
    logic        stall;
    logic        ready;

    logic        fv0, fv1, mis0, mis1;
    logic [31:0] pc0, pc1, link0, link1, maddr0, maddr1;

    always #5 clk = ~clk;

    pc_fetch_unit #(.XLEN(32), .RESET_ADDR(32'h100), .IALIGN(32)) dut0 (
        .clk(clk), .rst(rst), .ctrl_trans_instr_i(ctrl), .offset_i(offset),
        .branch_tkn_i(tkn), .tgt_addr_i(tgt), .c_instr_i(c_instr), .trap_i(trap),
        .mtvec_i(mtvec), .mret_i(mret), .mepc_i(mepc), .stall_i(stall),
        .fetch_ready_i(ready), .fetch_valid_o(fv0), .pc_o(pc0), .pc_link_o(link0),
        .misalign_o(mis0), .misalign_addr_o(maddr0)
    );

    pc_fetch_unit #(.XLEN(32), .RESET_ADDR(32'h0), .IALIGN(16)) dut1 (
        .clk(clk), .rst(rst), .ctrl_trans_instr_i(ctrl), .offset_i(offset),
        .branch_tkn_i(tkn), .tgt_addr_i(tgt), .c_instr_i(c_instr), .trap_i(trap),
        .mtvec_i(mtvec), .mret_i(mret), .mepc_i(mepc), .stall_i(stall),
        .fetch_ready_i(ready), .fetch_valid_o(fv1), .pc_o(pc1), .pc_link_o(link1),
        .misalign_o(mis1), .misalign_addr_o(maddr1)
    );

    typedef struct {
        logic        fv;
        logic [31:0] pc;
        logic [31:0] link;
        logic        mis;
        logic [31:0] maddr;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model state per instance: mode 0=boot 1=run 2=halt.
    logic [31:0] m_pc[2];
    logic [31:0] m_pt[2];
    logic [31:0] m_maddr[2];
    int          m_mode[2];
    bit          m_pv[2];
    bit          m_mis[2];

    function automatic int ia(int k);
        return (k == 0) ? 32 : 16;
    endfunction

    function automatic logic [31:0] rvec(int k);
        return (k == 0) ? 32'h100 : 32'h0;
    endfunction

    function automatic bit bad_align(int align, logic [31:0] t);
        if (align == 16) return (t % 2) != 0;
        return (t % 4) != 0;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, req);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pc[k] = rvec(k); m_mode[k] = 0; m_pv[k] = 0;
            m_mis[k] = 0; m_maddr[k] = 0; m_pt[k] = 0;
        end
    endtask

    // Predict this cycle's outputs, advance the model, then let the clock edge go.
    task automatic tick();
        exp_t        e;
        bit          has, adv;
        logic [31:0] t, step;
        for (int k = 0; k < 2; k++) begin
            step    = (ia(k) == 16 && c_instr) ? 32'd2 : 32'd4;
            e.fv    = (m_mode[k] == 1);
            e.pc    = m_pc[k];
            e.link  = m_pc[k] + step;
            e.mis   = m_mis[k];
            e.maddr = m_maddr[k];
            if (k == 0) q0.push_back(e); else q1.push_back(e);
        end
        for (int k = 0; k < 2; k++) begin
            step = (ia(k) == 16 && c_instr) ? 32'd2 : 32'd4;
            m_mis[k] = 0;
            if (rst) begin
                m_pc[k] = rvec(k); m_mode[k] = 0; m_pv[k] = 0; m_maddr[k] = 0;
            end else if (m_mode[k] == 0) begin
                m_mode[k] = 1;
            end else if (trap) begin
                m_pc[k] = mtvec; m_mode[k] = 1; m_pv[k] = 0;
            end else if (m_mode[k] == 1) begin
                adv = ready && !stall;
                has = 1; t = 0;
                if (mret) t = mepc;
                else if (ctrl == 2'd1) t = tgt - (tgt % 2);
                else if (ctrl == 2'd2 && tkn) t = m_pc[k] + offset;
                else has = 0;
                if (!m_pv[k] && has && bad_align(ia(k), t)) begin
                    m_mis[k] = 1; m_maddr[k] = t; m_mode[k] = 2; m_pv[k] = 0;
                end else if (adv) begin
                    if (m_pv[k]) m_pc[k] = m_pt[k];
                    else if (has) m_pc[k] = t;
                    else m_pc[k] = m_pc[k] + step;
                    m_pv[k] = 0;
                end else if (has && !m_pv[k]) begin
                    m_pv[k] = 1; m_pt[k] = t;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ctrl = 2'd0; tkn = 0; trap = 0; mret = 0; stall = 0; c_instr = 0; rst = 0;
    endtask

    // Monitor: compare every predicted cycle against what the DUTs present.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                chk("i32.fetch_valid", 32'(fv0), 32'(e.fv));
                chk("i32.pc", pc0, e.pc);
                chk("i32.pc_link", link0, e.link);
                chk("i32.misalign", 32'(mis0), 32'(e.mis));
                chk("i32.misalign_addr", maddr0, e.maddr);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                chk("i16.fetch_valid", 32'(fv1), 32'(e.fv));
                chk("i16.pc", pc1, e.pc);
                chk("i16.pc_link", link1, e.link);
                chk("i16.misalign", 32'(mis1), 32'(e.mis));
                chk("i16.misalign_addr", maddr1, e.maddr);
            end
        end
    end

    // Stimulus: directed scenarios followed by a randomized run.
    initial begin
        idle();
        rst = 1; ready = 1; offset = 0; tgt = 0; mtvec = 0; mepc = 0;
        @(posedge clk);
        #1;
        model_reset();
        tick();
        rst = 0;
        repeat (4) tick();

        // Branch taken / not taken from 0x200.
        trap = 1; mtvec = 32'h200; tick();
        idle(); ctrl = 2'd2; tkn = 1; offset = 32'hFFFF_FFF8; tick();
        idle(); trap = 1; mtvec = 32'h200; tick();
        idle(); ctrl = 2'd2; tkn = 0; tick();
        idle(); tick();

        // Jump captured while back-pressured, applied when ready returns.
        trap = 1; mtvec = 32'h10; tick();
        idle(); ready = 0; ctrl = 2'd1; tgt = 32'h301; tick();
        idle(); tick(); tick();
        ready = 1; tick();
        tick();

        // Misaligned jump for IALIGN=32 only, then trap recovery.
        ctrl = 2'd1; tgt = 32'h402; tick();
        idle(); tick(); tick();
        trap = 1; mtvec = 32'h80; tick();
        idle(); tick();

        // Compressed step, then trap+mret under stall with a pending redirect.
        trap = 1; mtvec = 32'h10; tick();
        idle(); c_instr = 1; tick();
        idle(); ready = 0; ctrl = 2'd1; tgt = 32'h500; tick();
        idle(); stall = 1; trap = 1; mret = 1; mepc = 32'h700; mtvec = 32'h40; tick();
        idle(); ready = 1; tick(); tick();

        // Wraparound, then reset while a redirect is pending.
        trap = 1; mtvec = 32'hFFFF_FFFC; tick();
        idle(); tick(); tick();
        ready = 0; ctrl = 2'd1; tgt = 32'h600; tick();
        idle(); rst = 1; tick();
        idle(); ready = 1; tick(); tick(); tick();

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            rst     = ($urandom_range(0, 199) == 0);
            trap    = ($urandom_range(0, 11) == 0);
            mret    = ($urandom_range(0, 11) == 0);
            ctrl    = 2'($urandom_range(0, 3));
            tkn     = 1'($urandom);
            c_instr = 1'($urandom);
            stall   = ($urandom_range(0, 3) == 0);
            ready   = ($urandom_range(0, 3) != 0);
            offset  = 32'($urandom_range(0, 255)) - 32'd128;
            tgt     = $urandom;
            mepc    = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            mtvec   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_FFFC);
            tick();
        end
        idle();
        tick();
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
